abr_masked_serial_adder_ctrl: RTL

//  Bit-serial sequencer for one masked full adder. Adds two WIDTH-bit Boolean-shared
//  (2-share) operands plus a shared carry-in, one bit per cycle, LSB first.

---
 rtl/abr_masked_add_pkg.sv | 13 +
 rtl/abr_masked_full_adder.sv | 39 +++
 rtl/abr_masked_serial_adder_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/abr_masked_add_pkg.sv
// Shared types for the masked serial adder: FSM state encoding and the 2-share bit type.
package abr_masked_add_pkg;

   typedef enum logic [1:0] {
      ADD_IDLE,
      ADD_RUN,
      ADD_FLUSH
   } masked_add_state_e;

   // Bit 0 is share 0, bit 1 is share 1; the two are only ever XORed off-chip.
   typedef logic [1:0] share_t;

endpackage

// File: rtl/abr_masked_full_adder.sv
// One-bit Boolean-masked full adder with a single registered output stage.
// The carry uses maj(x,y,c) = ((x^c)&(y^c))^c so only one masked AND (one rnd bit) is needed.
module abr_masked_full_adder
   import abr_masked_add_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   zeroize,
   input  share_t x,
   input  share_t y,
   input  share_t c_in,
   input  logic   rnd,
   output share_t s,
   output share_t c_out
);

   share_t a;
   share_t b;
   share_t q;

   assign a = x ^ c_in;
   assign b = y ^ c_in;

   // Cross terms are refreshed with rnd before joining the same-share product.
   assign q[0] = (a[0] & b[0]) ^ ((a[0] & b[1]) ^ rnd);
   assign q[1] = (a[1] & b[1]) ^ ((a[1] & b[0]) ^ rnd);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || zeroize) begin
         s     <= '0;
         c_out <= '0;
      end else begin
         s     <= x ^ y ^ c_in;
         c_out <= q ^ c_in;
      end
   end

endmodule

// File: rtl/abr_masked_serial_adder_ctrl.sv
// Bit-serial sequencer around one masked full adder: LSB-first ripple add of 2-share operands.
// Shares stay separated end to end; the carry is fed back through the adder's output register.
module abr_masked_serial_adder_ctrl
   import abr_masked_add_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             zeroize,
   input  logic             start_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] x0_i,
   input  logic [WIDTH-1:0] x1_i,
   input  logic [WIDTH-1:0] y0_i,
   input  logic [WIDTH-1:0] y1_i,
   input  logic [1:0]       cin_i,
   input  logic [WIDTH-1:0] rnd_i,
   output logic [WIDTH-1:0] sum0_o,
   output logic [WIDTH-1:0] sum1_o,
   output logic [1:0]       cout_o,
   output logic             valid_o
);

   localparam int               IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   masked_add_state_e state;
   masked_add_state_e state_nxt;

   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] x0_reg;
   logic [WIDTH-1:0] x1_reg;
   logic [WIDTH-1:0] y0_reg;
   logic [WIDTH-1:0] y1_reg;
   logic [WIDTH-1:0] rnd_reg;
   logic [WIDTH-1:0] sum0_reg;
   logic [WIDTH-1:0] sum1_reg;
   share_t           cin_reg;
   share_t           cout_reg;
   logic             valid_reg;

   share_t add_x;
   share_t add_y;
   share_t add_cin;
   logic   add_rnd;
   share_t add_s;
   share_t add_cout;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ADD_IDLE:  if (start_i) state_nxt = ADD_RUN;
         ADD_RUN:   if (idx == LAST_IDX) state_nxt = ADD_FLUSH;
         ADD_FLUSH: state_nxt = ADD_IDLE;
         default:   state_nxt = ADD_IDLE;
      endcase
   end

   // Adder sees all-zero inputs outside RUN so held shares never toggle it.
   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = '0;
      add_rnd = 1'b0;
      if (state == ADD_RUN) begin
         add_x   = {x1_reg[idx], x0_reg[idx]};
         add_y   = {y1_reg[idx], y0_reg[idx]};
         add_cin = (idx == '0) ? cin_reg : add_cout;
         add_rnd = rnd_reg[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || zeroize) begin
         state <= ADD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: operand, randomness and result registers are all cleared on reset/zeroize so no share survives an abort.
   always_ff @(posedge clk) begin
      if (!rst_n || zeroize) begin
         idx       <= '0;
         x0_reg    <= '0;
         x1_reg    <= '0;
         y0_reg    <= '0;
         y1_reg    <= '0;
         rnd_reg   <= '0;
         sum0_reg  <= '0;
         sum1_reg  <= '0;
         cin_reg   <= '0;
         cout_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= (state == ADD_FLUSH);
         unique case (state)
            ADD_IDLE: begin
               if (start_i) begin
                  x0_reg   <= x0_i;
                  x1_reg   <= x1_i;
                  y0_reg   <= y0_i;
                  y1_reg   <= y1_i;
                  rnd_reg  <= rnd_i;
                  cin_reg  <= cin_i;
                  sum0_reg <= '0;
                  sum1_reg <= '0;
                  cout_reg <= '0;
                  idx      <= '0;
               end
            end
            ADD_RUN: begin
               // Adder output lags by one step, so it belongs to the previous bit.
               if (idx != '0) begin
                  sum0_reg[idx - IDX_W'(1)] <= add_s[0];
                  sum1_reg[idx - IDX_W'(1)] <= add_s[1];
               end
               rnd_reg[idx] <= 1'b0;
               idx          <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            ADD_FLUSH: begin
               sum0_reg[WIDTH-1] <= add_s[0];
               sum1_reg[WIDTH-1] <= add_s[1];
               cout_reg          <= add_cout;
            end
            default: ;
         endcase
      end
   end

   abr_masked_full_adder u_fa (
      .clk     (clk),
      .rst_n   (rst_n),
      .zeroize (zeroize),
      .x       (add_x),
      .y       (add_y),
      .c_in    (add_cin),
      .rnd     (add_rnd),
      .s       (add_s),
      .c_out   (add_cout)
   );

   assign ready_o = (state == ADD_IDLE);
   assign sum0_o  = sum0_reg;
   assign sum1_o  = sum1_reg;
   assign cout_o  = cout_reg;
   assign valid_o = valid_reg;

endmodule
